// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a small byte FIFO and status register.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0024,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [31:0] data_address,
    input  logic [31:0] writedata,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        tx,
    output logic        irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] DEPTH = 4'(FIFO_DEPTH);
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t state;
    logic [7:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [3:0] count;
    logic overrun;
    logic [7:0] sh;
    logic [15:0] timer;
    logic [2:0] idx;
    logic hit_data, hit_stat, busy, empty, full, push, pop, bit_end, unused;

    assign hit_data = data_address == BASE_ADDR;
    assign hit_stat = data_address == BASE_ADDR + 32'd4;
    assign sel = hit_data | hit_stat;
    assign busy = state != IDLE;
    assign empty = count == 4'd0;
    assign full = count == DEPTH;
    assign irq = empty & ~busy;
    assign rdata = (memread & hit_stat) ? {25'b0, count[2:0], overrun, empty, full, busy} : 32'b0;
    assign push = memwrite & hit_data & ~full;
    assign pop = (state == IDLE) & ~empty;
    assign bit_end = timer == LAST;
    assign unused = ^writedata[31:8];

    always_ff @(posedge clk)
        if (push) mem[wp] <= writedata[7:0];

    // A write that finds the FIFO full is dropped even if a pop frees a slot on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            wp      <= push ? wp + PW'(1) : wp;
            rp      <= pop ? rp + PW'(1) : rp;
            count   <= count + {3'b0, push} - {3'b0, pop};
            overrun <= (memwrite & hit_data & full) | (overrun & ~(memwrite & hit_stat & writedata[3]));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            tx    <= 1'b1;
            sh    <= '0;
            timer <= '0;
            idx   <= '0;
        end else begin
            timer <= (state == IDLE || bit_end) ? 16'd0 : timer + 16'd1;
            case (state)
                IDLE: if (pop) begin
                    sh    <= mem[rp];
                    state <= START;
                    tx    <= 1'b0;
                end
                START: if (bit_end) begin
                    state <= DATA;
                    idx   <= 3'd0;
                    tx    <= sh[0];
                end
                DATA: if (bit_end) begin
                    sh    <= sh >> 1;
                    idx   <= idx + 3'd1;
                    state <= idx == 3'd7 ? STOP : DATA;
                    tx    <= idx == 3'd7 ? 1'b1 : sh[1];
                end
                STOP: if (bit_end) begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: scoreboard bench; expected bytes queued at write time, compared as frames leave tx.
module tb_uart_tx_mmio;
    localparam logic [31:0] BASE = 32'h1001_0024;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic memwrite = 1'b0;
    logic memread = 1'b0;
    logic [31:0] data_address = BASE + 32'd4;
    logic [31:0] writedata = 32'd0;
    logic [31:0] rdata;
    logic sel, tx, irq;

    int compared = 0;
    int mismatched = 0;
    int frames = 0;
    logic [7:0] exp_q[$];
    int idle_q[$];

    always #5 clk = ~clk;

    uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .memread(memread),
        .data_address(data_address), .writedata(writedata),
        .rdata(rdata), .sel(sel), .tx(tx), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Peek STATUS early in the cycle, then present a write for the coming edge.
    task automatic wr_peek(input logic [31:0] addr, input logic [31:0] data, input bit keep,
                           output logic [31:0] st);
        @(negedge clk);
        memread = 1'b1;
        data_address = BASE + 32'd4;
        #1 st = rdata;
        memread = 1'b0;
        memwrite = 1'b1;
        data_address = addr;
        writedata = data;
        if (keep) exp_q.push_back(data[7:0]);
        @(posedge clk);
        #1 memwrite = 1'b0;
        data_address = BASE + 32'd4;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] st, output logic s);
        @(negedge clk);
        memread = 1'b1;
        data_address = addr;
        #1 st = rdata;
        s = sel;
        memread = 1'b0;
        data_address = BASE + 32'd4;
    endtask

    // Frame monitor: samples every negedge, checks bit stability and data against the queue.
    initial begin : mon
        int n, start, last_end;
        bit ok, aborted;
        logic [9:0] bits;
        n = 0;
        last_end = -1;
        bits = '0;
        forever begin
            @(negedge clk);
            n++;
            if (reset && tx === 1'b0) begin
                ok = 1'b1;
                aborted = 1'b0;
                start = n;
                for (int i = 0; i < 10 * CPB; i++) begin
                    if (i > 0) begin
                        @(negedge clk);
                        n++;
                    end
                    if (!reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (i % CPB == 0) bits[i / CPB] = tx;
                    else if (tx !== bits[i / CPB]) ok = 1'b0;
                end
                if (!aborted) begin
                    chk("frame_start", 32'(bits[0]), 32'd0);
                    chk("frame_stop", 32'(bits[9]), 32'd1);
                    chk("frame_stable", 32'(ok), 32'd1);
                    if (exp_q.size() == 0) chk("frame_unexpected", 32'd1, 32'd0);
                    else chk("frame_data", 32'(bits[8:1]), 32'(exp_q.pop_front()));
                    if (last_end >= 0) idle_q.push_back(start - last_end - 1);
                    last_end = n;
                    frames++;
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] st;
        logic s;
        int busy_n, f0;
        bit seen;
        logic [31:0] exp_st [6];
        logic [7:0] burst [6];
        exp_st = '{32'h04, 32'h10, 32'h11, 32'h21, 32'h31, 32'h43};
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        repeat (3) @(negedge clk);
        reset = 1'b1;
        rd(BASE + 32'd4, st, s);
        chk("reset_status", st, 32'h4);
        chk("reset_sel", 32'(s), 32'd1);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_irq", 32'(irq), 32'd1);

        wr_peek(BASE, 32'hFFFF_FFA5, 1'b1, st);
        @(negedge clk);
        chk("lat_tx_high", 32'(tx), 32'd1);
        memread = 1'b1;
        data_address = BASE + 32'd4;
        busy_n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (i == 0) begin
                chk("lat_tx_low", 32'(tx), 32'd0);
                chk("frame_irq_low", 32'(irq), 32'd0);
            end
            if (rdata[0]) busy_n++;
            else break;
        end
        memread = 1'b0;
        chk("busy_cycles", 32'(busy_n), 32'd160);
        chk("irq_after", 32'(irq), 32'd1);

        rd(BASE + 32'd8, st, s);
        chk("dec_plus8_rdata", st, 32'd0);
        chk("dec_plus8_sel", 32'(s), 32'd0);
        rd(BASE - 32'd4, st, s);
        chk("dec_minus4_rdata", st, 32'd0);
        chk("dec_minus4_sel", 32'(s), 32'd0);
        rd(BASE, st, s);
        chk("dec_txdata_rdata", st, 32'd0);
        chk("dec_txdata_sel", 32'(s), 32'd1);
        @(negedge clk);
        data_address = BASE + 32'd4;
        #1 chk("dec_noread_rdata", rdata, 32'd0);
        wr_peek(BASE + 32'd8, 32'h77, 1'b0, st);
        rd(BASE + 32'd4, st, s);
        chk("dec_wr_nochange", st, 32'h4);

        f0 = frames;
        idle_q.delete();
        for (int i = 0; i < 6; i++) begin
            wr_peek(BASE, {24'hABCDEF, burst[i]}, i < 5, st);
            chk($sformatf("burst_status%0d", i), st, exp_st[i]);
        end
        rd(BASE + 32'd4, st, s);
        chk("overrun_set", st, 32'h4B);
        wr_peek(BASE + 32'd4, 32'h8, 1'b0, st);
        rd(BASE + 32'd4, st, s);
        chk("overrun_clear", st, 32'h43);

        for (int i = 0; i < 1500 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        repeat (250) @(negedge clk);
        chk("burst_frames", 32'(frames - f0), 32'd5);
        chk("burst_gaps_n", 32'(idle_q.size()), 32'd5);
        for (int i = 1; i < 5 && i < idle_q.size(); i++)
            chk($sformatf("burst_gap%0d", i), 32'(idle_q[i]), 32'd1);
        rd(BASE + 32'd4, st, s);
        chk("drained_status", st, 32'h4);
        chk("drained_irq", 32'(irq), 32'd1);

        wr_peek(BASE, 32'h5A, 1'b0, st);
        wr_peek(BASE, 32'hC3, 1'b0, st);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = tx == 1'b0;
        end
        chk("mid_fall_seen", 32'(seen), 32'd1);
        repeat (CPB + 3 * CPB + CPB / 2) @(negedge clk);
        chk("mid_bit3", 32'(tx), 32'd1);
        f0 = frames;
        #2 reset = 1'b0;
        #1 chk("mid_reset_tx", 32'(tx), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        rd(BASE + 32'd4, st, s);
        chk("mid_reset_status", st, 32'h4);
        repeat (400) @(negedge clk);
        chk("mid_no_frames", 32'(frames - f0), 32'd0);
        chk("mid_tx_idle", 32'(tx), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
